// File: rtl/exec_ctrl_alu.sv
// Execute-stage control decode and RV32IM ALU for the single-cycle core.
// Decode and ALU outputs are combinational; result/zero also get one register stage.
module exec_ctrl_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            reg_write,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump,
  output logic            jump_r,
  output logic            auipc,
  output logic [2:0]      alu_op,
  output logic [4:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q
);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SLL    = 5'b00101,
    ALU_SRL    = 5'b00110,
    ALU_SRA    = 5'b00111,
    ALU_SLT    = 5'b01000,
    ALU_SLTU   = 5'b01001,
    ALU_PASSB  = 5'b01010,
    ALU_SEQ    = 5'b01011,
    ALU_SGE    = 5'b01100,
    ALU_SGEU   = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_fn_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] AOP_MEM    = 3'b000;
  localparam logic [2:0] AOP_BRANCH = 3'b001;
  localparam logic [2:0] AOP_R      = 3'b010;
  localparam logic [2:0] AOP_I      = 3'b011;
  localparam logic [2:0] AOP_PASS   = 3'b100;

  logic illegal_opc;
  logic illegal_fn;
  alu_fn_e fn;

  function automatic alu_fn_e base_fn(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    jump_r      = 1'b0;
    auipc       = 1'b0;
    alu_op      = AOP_MEM;
    illegal_opc = 1'b0;
    case (opcode)
      OPC_R: begin
        reg_write = 1'b1;
        alu_op    = AOP_R;
      end
      OPC_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = AOP_I;
      end
      OPC_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        alu_op = AOP_BRANCH;
      end
      OPC_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
      end
      OPC_JALR: begin
        jump_r    = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = AOP_PASS;
      end
      OPC_AUIPC: begin
        auipc     = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      default: illegal_opc = 1'b1;
    endcase
  end

  // Branch ops are chosen so that a zero result means the branch is taken.
  always_comb begin
    fn         = ALU_ADD;
    illegal_fn = 1'b0;
    case (alu_op)
      AOP_PASS: fn = ALU_PASSB;
      AOP_BRANCH: begin
        case (funct3)
          3'b000: fn = ALU_SUB;
          3'b001: fn = ALU_SEQ;
          3'b100: fn = ALU_SGE;
          3'b101: fn = ALU_SLT;
          3'b110: fn = ALU_SGEU;
          3'b111: fn = ALU_SLTU;
          default: begin
            fn         = ALU_SUB;
            illegal_fn = 1'b1;
          end
        endcase
      end
      AOP_R: begin
        if (funct7 == 7'b0000000) begin
          fn = base_fn(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) fn = ALU_SUB;
          else if (funct3 == 3'b101) fn = ALU_SRA;
          else illegal_fn = 1'b1;
        end else if (funct7 == 7'b0000001) begin
          fn = alu_fn_e'({2'b10, funct3});
        end else begin
          illegal_fn = 1'b1;
        end
      end
      AOP_I: begin
        fn = base_fn(funct3);
        if (funct3 == 3'b101 && funct7[5]) fn = ALU_SRA;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal_fn = 1'b1;
      end
      default: fn = ALU_ADD;
    endcase
  end

  assign alu_ctrl = fn;
  assign illegal  = illegal_opc | illegal_fn;

  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [4:0]        shamt;
  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic              div_by_zero;
  logic [XLEN-1:0]   div_b;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   quot_u;
  logic [XLEN-1:0]   rem_u;

  assign op_a  = rs1_val;
  assign op_b  = alu_src ? imm : rs2_val;
  assign shamt = op_b[4:0];

  // One shared 64-bit multiplier; operand extension picks the signedness.
  assign a_signed = (fn == ALU_MULH) || (fn == ALU_MULHSU);
  assign b_signed = (fn == ALU_MULH);
  assign a_ext    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
  assign b_ext    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
  assign prod     = a_ext * b_ext;

  // Divisor forced to 1 on zero and on MIN/-1: the latter then yields MIN rem 0 naturally.
  assign div_by_zero = (op_b == '0);
  assign div_b = (div_by_zero || (op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1))
                 ? {{(XLEN-1){1'b0}}, 1'b1} : op_b;
  assign quot_s = $signed(op_a) / $signed(div_b);
  assign rem_s  = $signed(op_a) % $signed(div_b);
  assign quot_u = op_a / div_b;
  assign rem_u  = op_a % div_b;

  always_comb begin
    result = '0;
    case (fn)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_OR:     result = op_a | op_b;
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SLL:    result = op_a << shamt;
      ALU_SRL:    result = op_a >> shamt;
      ALU_SRA:    result = $signed(op_a) >>> shamt;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB:  result = op_b;
      ALU_SEQ:    result = {{(XLEN-1){1'b0}}, op_a == op_b};
      ALU_SGE:    result = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
      ALU_SGEU:   result = {{(XLEN-1){1'b0}}, op_a >= op_b};
      ALU_MUL:    result = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[2*XLEN-1:XLEN];
      ALU_DIV:    result = div_by_zero ? '1 : quot_s;
      ALU_DIVU:   result = div_by_zero ? '1 : quot_u;
      ALU_REM:    result = div_by_zero ? op_a : rem_s;
      ALU_REMU:   result = div_by_zero ? op_a : rem_u;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_alu.sv
// Bench for exec_ctrl_alu: instruction-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_exec_ctrl_alu;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic        branch, jump, jump_r, auipc;
  logic [2:0]  alu_op;
  logic [4:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [31:0] result_q;
  logic        zero_q;

  int check_count = 0;
  int pass_count  = 0;

  exec_ctrl_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
    .jump(jump), .jump_r(jump_r), .auipc(auipc), .alu_op(alu_op),
    .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .illegal(illegal),
    .result_q(result_q), .zero_q(zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SLT, M_SLTU,
    M_PASSB, M_SEQ, M_SGE, M_SGEU, M_MUL, M_MULH, M_MULHSU, M_MULHU,
    M_DIV, M_DIVU, M_REM, M_REMU
  } mn_e;

  typedef struct {
    logic [8:0]  strobes;
    logic [2:0]  alu_op;
    logic [4:0]  ctrl;
    logic        illegal;
    logic [31:0] result;
  } exp_t;

  function automatic logic [4:0] mn_code(input mn_e m);
    case (m)
      M_ADD: return 5'd0;    M_SUB: return 5'd1;    M_AND: return 5'd2;
      M_OR: return 5'd3;     M_XOR: return 5'd4;    M_SLL: return 5'd5;
      M_SRL: return 5'd6;    M_SRA: return 5'd7;    M_SLT: return 5'd8;
      M_SLTU: return 5'd9;   M_PASSB: return 5'd10; M_SEQ: return 5'd11;
      M_SGE: return 5'd12;   M_SGEU: return 5'd13;  M_MUL: return 5'd16;
      M_MULH: return 5'd17;  M_MULHSU: return 5'd18; M_MULHU: return 5'd19;
      M_DIV: return 5'd20;   M_DIVU: return 5'd21;  M_REM: return 5'd22;
      default: return 5'd23;
    endcase
  endfunction

  function automatic mn_e r_base(input logic [2:0] f3);
    mn_e tbl [8] = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
    return tbl[f3];
  endfunction

  function automatic logic [31:0] alu_eval(input mn_e m, input logic [31:0] a, input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ub = longint'({32'b0, b});
    longint      p;
    logic [63:0] pu;
    case (m)
      M_ADD:   return a + b;
      M_SUB:   return a - b;
      M_AND:   return a & b;
      M_OR:    return a | b;
      M_XOR:   return a ^ b;
      M_SLL:   return a << b[4:0];
      M_SRL:   return a >> b[4:0];
      M_SRA:   return 32'(sa >>> b[4:0]);
      M_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      M_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      M_PASSB: return b;
      M_SEQ:   return (a == b) ? 32'd1 : 32'd0;
      M_SGE:   return (sa >= sb) ? 32'd1 : 32'd0;
      M_SGEU:  return (a >= b) ? 32'd1 : 32'd0;
      M_MUL:   begin p = sa * sb; return p[31:0]; end
      M_MULH:  begin p = sa * sb; return p[63:32]; end
      M_MULHSU: begin p = sa * ub; return p[63:32]; end
      M_MULHU: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      M_DIV:   begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      M_DIVU:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      M_REM:   begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Strobe order: {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_r, auipc}
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] im);
    exp_t        e;
    mn_e         m;
    mn_e         mext [8] = '{M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU};
    logic [31:0] b;
    e.strobes = 9'b0; e.alu_op = 3'b000; e.illegal = 1'b0; m = M_ADD;
    case (opc)
      OPC_R: begin
        e.strobes = 9'b100000000; e.alu_op = 3'b010;
        if (f7 == 7'h00) m = r_base(f3);
        else if (f7 == 7'h20) begin
          if (f3 == 3'd0) m = M_SUB;
          else if (f3 == 3'd5) m = M_SRA;
          else e.illegal = 1'b1;
        end
        else if (f7 == 7'h01) m = mext[f3];
        else e.illegal = 1'b1;
      end
      OPC_I: begin
        e.strobes = 9'b110000000; e.alu_op = 3'b011; m = r_base(f3);
        if (f3 == 3'd5 && f7[5]) m = M_SRA;
        if (f3 == 3'd1 && f7 != 7'h00) e.illegal = 1'b1;
      end
      OPC_LOAD:  e.strobes = 9'b111010000;
      OPC_STORE: e.strobes = 9'b010100000;
      OPC_BRANCH: begin
        e.strobes = 9'b000001000; e.alu_op = 3'b001;
        case (f3)
          3'd0: m = M_SUB;  3'd1: m = M_SEQ;  3'd4: m = M_SGE;
          3'd5: m = M_SLT;  3'd6: m = M_SGEU; 3'd7: m = M_SLTU;
          default: begin m = M_SUB; e.illegal = 1'b1; end
        endcase
      end
      OPC_JAL:   e.strobes = 9'b100000100;
      OPC_JALR:  e.strobes = 9'b110000010;
      OPC_LUI:   begin e.strobes = 9'b110000000; e.alu_op = 3'b100; m = M_PASSB; end
      OPC_AUIPC: e.strobes = 9'b110000001;
      default:   e.illegal = 1'b1;
    endcase
    b = e.strobes[7] ? im : rs2;
    e.ctrl = mn_code(m);
    e.result = alu_eval(m, a, b);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Registered expectations follow the model's view of the inputs at each edge.
  logic [31:0] exp_rq;
  logic        exp_zq;
  logic        q_valid = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    e = model(opcode, funct3, funct7, rs1_val, rs2_val, imm);
    exp_rq  <= rst ? 32'd0 : e.result;
    exp_zq  <= rst ? 1'b0 : (e.result == 32'd0);
    q_valid <= 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_valid) begin
      e = model(opcode, funct3, funct7, rs1_val, rs2_val, imm);
      checkOutput("result", result, e.result);
      checkOutput("zero", 32'(zero), 32'(e.result == 32'd0));
      checkOutput("illegal", 32'(illegal), 32'(e.illegal));
      checkOutput("strobes", 32'({reg_write, alu_src, mem_read, mem_write, mem_to_reg,
                                  branch, jump, jump_r, auipc}), 32'(e.strobes));
      checkOutput("alu_op", 32'(alu_op), 32'(e.alu_op));
      checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
      checkOutput("result_q", result_q, exp_rq);
      checkOutput("zero_q", 32'(zero_q), 32'(exp_zq));
    end
  end

  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    @(posedge clk);
    #1;
    opcode = opc; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    #2;
  endtask

  logic [6:0]  opc_list [10] = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                 OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, 7'h7F};
  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h5};

  function automatic logic [31:0] pick_val();
    if ($urandom_range(0, 1) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [6:0] rf7;
    rst = 1'b1;
    opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
    rs1_val = 32'b0; rs2_val = 32'b0; imm = 32'b0;

    // Register stage: reset clears it, combinational path keeps working.
    applyStimulus(OPC_R, 3'd0, 7'h00, 32'd2, 32'd3, 32'd0);
    checkOutput("comb_in_reset", result, 32'd5);
    @(posedge clk); #1;
    checkOutput("rq_reset", result_q, 32'd0);
    checkOutput("zq_reset", 32'(zero_q), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rq_add", result_q, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rq_rereset", result_q, 32'd0);
    rst = 1'b0;

    applyStimulus(OPC_R, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0);
    checkOutput("r_add", result, 32'd12);
    checkOutput("r_add_rw", 32'(reg_write), 32'd1);
    applyStimulus(OPC_R, 3'd0, 7'h20, 32'd5, 32'd7, 32'd0);
    checkOutput("r_sub", result, 32'hFFFFFFFE);
    checkOutput("r_sub_zero", 32'(zero), 32'd0);

    applyStimulus(OPC_I, 3'd5, 7'h20, 32'h80000000, 32'd0, 32'h404);
    checkOutput("srai", result, 32'hF8000000);
    applyStimulus(OPC_I, 3'd5, 7'h00, 32'h80000000, 32'd0, 32'h4);
    checkOutput("srli", result, 32'h08000000);

    applyStimulus(OPC_BRANCH, 3'd1, 7'h00, 32'd3, 32'd3, 32'd0);
    checkOutput("bne_eq", 32'(zero), 32'd0);
    applyStimulus(OPC_BRANCH, 3'd6, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0);
    checkOutput("bltu", 32'(zero), 32'd1);
    applyStimulus(OPC_BRANCH, 3'd5, 7'h00, 32'hFFFFFFFF, 32'd0, 32'd0);
    checkOutput("bge_neg", 32'(zero), 32'd0);
    applyStimulus(OPC_BRANCH, 3'd0, 7'h00, 32'd9, 32'd9, 32'd0);
    checkOutput("beq_zero", 32'(zero), 32'd1);
    checkOutput("beq_branch", 32'(branch), 32'd1);

    applyStimulus(OPC_R, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    checkOutput("mulhu", result, 32'hFFFFFFFE);
    applyStimulus(OPC_R, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    checkOutput("div_ovf", result, 32'h80000000);
    applyStimulus(OPC_R, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    checkOutput("rem_ovf", result, 32'd0);
    applyStimulus(OPC_R, 3'd7, 7'h01, 32'd9, 32'd0, 32'd0);
    checkOutput("remu_dz", result, 32'd9);
    applyStimulus(OPC_R, 3'd5, 7'h01, 32'd7, 32'd0, 32'd0);
    checkOutput("divu_dz", result, 32'hFFFFFFFF);
    applyStimulus(OPC_R, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 32'd0);
    checkOutput("div_trunc", result, 32'hFFFFFFFD);
    applyStimulus(OPC_R, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 32'd0);
    checkOutput("rem_trunc", result, 32'hFFFFFFFF);

    applyStimulus(OPC_LOAD, 3'd2, 7'h00, 32'h1000, 32'h55, 32'h20);
    checkOutput("load_res", result, 32'h1020);
    checkOutput("load_strb", 32'({mem_read, mem_to_reg, alu_src}), 32'h7);
    applyStimulus(OPC_STORE, 3'd2, 7'h00, 32'h1000, 32'h55, 32'h8);
    checkOutput("store_strb", 32'({mem_write, reg_write}), 32'h2);
    applyStimulus(OPC_LUI, 3'd0, 7'h00, 32'hDEAD, 32'hBEEF, 32'h12345000);
    checkOutput("lui", result, 32'h12345000);
    applyStimulus(7'h7F, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3);
    checkOutput("illegal_opc", 32'(illegal), 32'd1);
    checkOutput("illegal_strb", 32'({reg_write, alu_src, mem_read, mem_write, mem_to_reg,
                                     branch, jump, jump_r, auipc}), 32'd0);
    applyStimulus(OPC_BRANCH, 3'd2, 7'h00, 32'd4, 32'd4, 32'd0);
    checkOutput("br_f3_illegal", 32'(illegal), 32'd1);
    applyStimulus(OPC_I, 3'd1, 7'h20, 32'd1, 32'd0, 32'h403);
    checkOutput("slli_f7_illegal", 32'(illegal), 32'd1);

    // Further coverage relies on the per-cycle model comparison.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      applyStimulus(opc_list[$urandom_range(0, 9)], 3'($urandom), rf7,
                    pick_val(), pick_val(), pick_val());
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
